// File: rtl/hazard_pkg.sv
// Shared constants and the last-issue record type for the hazard scoreboard.
package hazard_pkg;

   localparam int RF_SCALAR  = 0;
   localparam int RF_VECTOR  = 1;
   localparam int FWD_RF     = 0;
   localparam int DEF_WB_LAT = 3;
   localparam int LI_W       = 8;

   typedef struct packed {
      logic            valid;
      logic [LI_W-1:0] rf;
      logic [LI_W-1:0] rd;
   } last_issue_t;

endpackage

// File: rtl/hazard_rf_track.sv
// Countdown scoreboard for one register file: per-register pending-write counter and load flag.
import hazard_pkg::*;

module hazard_rf_track #(
   parameter int NUM_REGS = 32,
   parameter int NUM_SRC  = 2,
   parameter int WB_LAT   = DEF_WB_LAT,
   parameter bit ZERO_EN  = 1'b0,
   localparam int AW      = $clog2(NUM_REGS),
   localparam int CW      = $clog2(WB_LAT + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  set_en,
   input  logic [AW-1:0]         set_addr,
   input  logic                  set_ld,
   input  logic                  clr_en,
   input  logic [AW-1:0]         clr_addr,
   input  logic [NUM_SRC*AW-1:0] src_addr,
   output logic [NUM_SRC*CW-1:0] src_cnt,
   output logic [NUM_SRC-1:0]    src_ld,
   input  logic [AW-1:0]         dst_addr,
   output logic [CW-1:0]         dst_cnt
);

   logic [CW-1:0]       cnt_r [NUM_REGS];
   logic [NUM_REGS-1:0] ld_r;

   // Counter update: a new issue wins over flush-clear, which wins over the decrement.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            cnt_r[i] <= '0;
         end
         ld_r <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (set_en && set_addr == AW'(i) && !(ZERO_EN && i == 0)) begin
               cnt_r[i] <= CW'(WB_LAT);
               ld_r[i]  <= set_ld;
            end else if (clr_en && clr_addr == AW'(i)) begin
               cnt_r[i] <= '0;
            end else if (cnt_r[i] != '0) begin
               cnt_r[i] <= cnt_r[i] - CW'(1);
            end else begin
               cnt_r[i] <= cnt_r[i];
            end
         end
      end
   end

   // Source and destination lookups.
   always_comb begin
      src_cnt = '0;
      src_ld  = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         src_cnt[s*CW +: CW] = cnt_r[src_addr[s*AW +: AW]];
         src_ld[s]           = ld_r[src_addr[s*AW +: AW]];
      end
      dst_cnt = cnt_r[dst_addr];
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit beside decode: RAW, load-use and WAW detection, branch flush, stall counter.
// Build option: HAZARD_FWD_EN enables bypass selects; otherwise any pending source stalls.
import hazard_pkg::*;

module hazard_scoreboard #(
   parameter int NUM_RF   = 2,
   parameter int NUM_REGS = 32,
   parameter int NUM_SRC  = 2,
   parameter int WB_LAT   = DEF_WB_LAT,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(NUM_REGS),
   localparam int CW      = $clog2(WB_LAT + 1),
   localparam int RFW     = (NUM_RF > 1) ? $clog2(NUM_RF) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [RFW-1:0]        id_rf,
   input  logic [NUM_SRC*AW-1:0] id_src_addr,
   input  logic [NUM_SRC-1:0]    id_src_used,
   input  logic [AW-1:0]         id_dst_addr,
   input  logic                  id_dst_we,
   input  logic                  id_is_load,
   input  logic                  ex_flush,
   output logic                  stall,
   output logic                  issue,
   output logic [NUM_SRC*CW-1:0] fwd_sel,
   output logic [31:0]           stall_cycles
);

   logic [NUM_SRC*CW-1:0] src_cnt_a_s [NUM_RF];
   logic [NUM_SRC-1:0]    src_ld_a_s  [NUM_RF];
   logic [CW-1:0]         dst_cnt_a_s [NUM_RF];
   logic [NUM_SRC*CW-1:0] src_cnt_s;
   logic [NUM_SRC-1:0]    src_ld_s;
   logic [CW-1:0]         dst_cnt_s;
   logic [CW-1:0]         p_s;
   logic [NUM_SRC*CW-1:0] fwd_sel_s;
   logic                  haz_s;
   logic                  waw_s;
   logic                  stall_s;
   logic                  issue_s;
   last_issue_t           li_r;
   logic [31:0]           stall_cycles_r;

   for (genvar f = 0; f < NUM_RF; f++) begin : g_trk
      hazard_rf_track #(
         .NUM_REGS (NUM_REGS),
         .NUM_SRC  (NUM_SRC),
         .WB_LAT   (WB_LAT),
         .ZERO_EN  ((f == RF_SCALAR) && (ZERO_REG != 0))
      ) u_trk (
         .clk      (clk),
         .rst      (rst),
         .set_en   (issue_s && id_dst_we && (id_rf == RFW'(f))),
         .set_addr (id_dst_addr),
         .set_ld   (id_is_load),
         .clr_en   (ex_flush && li_r.valid && (li_r.rf == LI_W'(f))),
         .clr_addr (li_r.rd[AW-1:0]),
         .src_addr (id_src_addr),
         .src_cnt  (src_cnt_a_s[f]),
         .src_ld   (src_ld_a_s[f]),
         .dst_addr (id_dst_addr),
         .dst_cnt  (dst_cnt_a_s[f])
      );
   end

   // Hazard detection and bypass selection for the decode instruction.
   always_comb begin
      src_cnt_s = '0;
      src_ld_s  = '0;
      dst_cnt_s = '0;
      p_s       = '0;
      fwd_sel_s = '0;
      haz_s     = 1'b0;
      if (int'(id_rf) < NUM_RF) begin
         src_cnt_s = src_cnt_a_s[id_rf];
         src_ld_s  = src_ld_a_s[id_rf];
         dst_cnt_s = dst_cnt_a_s[id_rf];
      end else begin
         src_cnt_s = '0;
         src_ld_s  = '0;
         dst_cnt_s = '0;
      end
      for (int s = 0; s < NUM_SRC; s++) begin
         p_s = src_cnt_s[s*CW +: CW];
         if (id_src_used[s]) begin
`ifdef HAZARD_FWD_EN
            // Load data only exists once the load reaches WB (count 1).
            haz_s = haz_s | (src_ld_s[s] & (p_s > CW'(1)));
            fwd_sel_s[s*CW +: CW] = p_s;
`else
            // No write-through: any pending write stalls, load-use is subsumed.
            haz_s = haz_s | (p_s != '0) | (src_ld_s[s] & (p_s > CW'(1)));
            fwd_sel_s[s*CW +: CW] = '0;
`endif
         end else begin
            fwd_sel_s[s*CW +: CW] = '0;
         end
      end
      waw_s   = id_dst_we & (dst_cnt_s > CW'(1));
      stall_s = id_valid & ~ex_flush & (haz_s | waw_s);
      issue_s = id_valid & ~stall_s & ~ex_flush;
   end

   // Last issued writer, so a flush can cancel its pending write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         li_r <= '0;
      end else begin
         li_r.valid <= issue_s & id_dst_we;
         li_r.rf    <= LI_W'(id_rf);
         li_r.rd    <= LI_W'(id_dst_addr);
      end
   end

   // Saturating count of stalled decode cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_r <= 32'd0;
      end else if (id_valid && stall_s && (stall_cycles_r != 32'hFFFF_FFFF)) begin
         stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign stall        = stall_s;
   assign issue        = issue_s;
   assign fwd_sel      = fwd_sel_s;
   assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised + directed bench for hazard_scoreboard against a commit-time reference model.
module tb_hazard_scoreboard;

   localparam int WB = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        id_valid = 1'b0;
   logic [0:0]  id_rf = 1'b0;
   logic [9:0]  id_src_addr = '0;
   logic [1:0]  id_src_used = '0;
   logic [4:0]  id_dst_addr = '0;
   logic        id_dst_we = 1'b0;
   logic        id_is_load = 1'b0;
   logic        ex_flush = 1'b0;
   logic        stall;
   logic        issue;
   logic [3:0]  fwd_sel;
   logic [31:0] stall_cycles;

   hazard_scoreboard dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rf(id_rf),
      .id_src_addr(id_src_addr), .id_src_used(id_src_used),
      .id_dst_addr(id_dst_addr), .id_dst_we(id_dst_we), .id_is_load(id_is_load),
      .ex_flush(ex_flush), .stall(stall), .issue(issue), .fwd_sel(fwd_sel),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   // Reference model: each pending write is described by the cycle at which it commits.
   longint      now = 0;
   longint      ready_t [2][32];
   bit          ld_m [2][32];
   bit          li_v;
   int          li_f, li_r;
   int unsigned sc_m;

   int          n_cmp = 0;
   int          n_err = 0;
   int unsigned obs_stall, obs_issue, obs_fwd, obs_sc;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, now);
      end
   endtask

   function automatic int pend(input int f, input int r);
      return (ready_t[f][r] > now) ? int'(ready_t[f][r] - now) : 0;
   endfunction

   task automatic model_clear();
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < 32; r++) begin
            ready_t[f][r] = 0;
            ld_m[f][r]    = 1'b0;
         end
      li_v = 1'b0;
      sc_m = 0;
   endtask

   task automatic step(input bit v, input int rf, input int a0, input int a1,
                       input bit [1:0] used, input int dst, input bit we,
                       input bit ld, input bit fl);
      bit haz, e_stall, e_issue;
      int p, a;
      int unsigned e_fwd;
      @(negedge clk);
      id_valid    = v;
      id_rf       = 1'(rf);
      id_src_addr = {5'(a1), 5'(a0)};
      id_src_used = used;
      id_dst_addr = 5'(dst);
      id_dst_we   = we;
      id_is_load  = ld;
      ex_flush    = fl;
      #1;
      haz   = 1'b0;
      e_fwd = 0;
      for (int s = 0; s < 2; s++) begin
         a = (s == 0) ? a0 : a1;
         if (used[s]) begin
            p = pend(rf, a);
`ifdef HAZARD_FWD_EN
            if (ld_m[rf][a] && p > 1) haz = 1'b1;
            e_fwd = e_fwd | (int'(p) << (2 * s));
`else
            if (p > 0) haz = 1'b1;
`endif
         end
      end
      if (we && pend(rf, dst) > 1) haz = 1'b1;
      e_stall = v && !fl && haz;
      e_issue = v && !e_stall && !fl;
      obs_stall = 32'(stall);
      obs_issue = 32'(issue);
      obs_fwd   = 32'(fwd_sel);
      obs_sc    = stall_cycles;
      check("stall", obs_stall, 32'(e_stall));
      check("issue", obs_issue, 32'(e_issue));
      check("fwd_sel", obs_fwd, e_fwd);
      check("stall_cycles", obs_sc, sc_m);
      if (e_stall && sc_m != 32'hFFFF_FFFF) sc_m++;
      @(posedge clk);
      if (fl && li_v) ready_t[li_f][li_r] = now;
      if (e_issue && we && !(rf == 0 && dst == 0)) begin
         ready_t[rf][dst] = now + 1 + WB;
         ld_m[rf][dst]    = ld;
      end
      li_v = e_issue && we;
      li_f = rf;
      li_r = dst;
      now++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b0;
      id_valid = 1'b0;
      id_src_used = '0;
      ex_flush = 1'b0;
      #1;
      check("rst_stall", 32'(stall), 0);
      check("rst_issue", 32'(issue), 0);
      check("rst_fwd", 32'(fwd_sel), 0);
      check("rst_sc", stall_cycles, 0);
      model_clear();
      @(posedge clk);
      #2 rst = 1'b1;
      now++;
   endtask

   int unsigned sc0;

   initial begin
      model_clear();
      repeat (2) @(posedge clk);
      reset_pulse();
      idle(2);

      // RAW on an ALU result
      step(1, 0, 0, 0, 2'b00, 1, 1, 0, 0);
      step(1, 0, 1, 0, 2'b01, 9, 1, 0, 0);
`ifdef HAZARD_FWD_EN
      check("raw_stall", obs_stall, 0);
      check("raw_fwd3", obs_fwd & 32'd3, 3);
      step(1, 0, 1, 0, 2'b01, 0, 0, 0, 0);
      check("raw_fwd2", obs_fwd & 32'd3, 2);
`else
      check("raw_stall_nofwd", obs_stall, 1);
`endif
      idle(4);

      // Load-use
      step(1, 0, 0, 0, 2'b00, 2, 1, 1, 0);
      step(1, 0, 2, 0, 2'b01, 0, 0, 0, 0);
      sc0 = obs_sc;
      check("lu_stall1", obs_stall, 1);
      step(1, 0, 2, 0, 2'b01, 0, 0, 0, 0);
      check("lu_stall2", obs_stall, 1);
      step(1, 0, 2, 0, 2'b01, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
      check("lu_issue", obs_issue, 1);
      check("lu_fwd1", obs_fwd & 32'd3, 1);
      check("lu_cycles", obs_sc - sc0, 2);
`endif
      idle(4);

      // WAW and file independence
      step(1, 0, 0, 0, 2'b00, 3, 1, 0, 0);
      step(1, 1, 3, 0, 2'b01, 4, 0, 0, 0);
      check("vec_stall", obs_stall, 0);
      check("vec_fwd", obs_fwd, 0);
      step(1, 0, 0, 0, 2'b00, 3, 1, 0, 0);
      check("waw_stall", obs_stall, 1);
      step(1, 0, 0, 0, 2'b00, 3, 1, 0, 0);
      check("waw_issue", obs_issue, 1);
      idle(4);

      // Zero register
      step(1, 0, 0, 0, 2'b00, 0, 1, 0, 0);
      step(1, 0, 0, 0, 2'b11, 6, 0, 0, 0);
      check("x0_stall", obs_stall, 0);
      check("x0_fwd", obs_fwd, 0);
      idle(4);

      // Branch flush cancels the last issued writer
      step(1, 0, 0, 0, 2'b00, 5, 1, 0, 0);
      step(1, 0, 5, 0, 2'b01, 0, 0, 0, 1);
      check("fl_issue", obs_issue, 0);
      step(1, 0, 5, 0, 2'b01, 0, 0, 0, 0);
      check("fl_stall", obs_stall, 0);
      check("fl_fwd", obs_fwd, 0);
      idle(4);

      // Reset with a load in flight
      step(1, 0, 0, 0, 2'b00, 7, 1, 1, 0);
      idle(1);
      reset_pulse();
      step(1, 0, 7, 0, 2'b01, 0, 0, 0, 0);
      check("rs_fwd", obs_fwd, 0);
      check("rs_stall", obs_stall, 0);

      // Random traffic over a small register window to provoke hazards
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 149) == 0) reset_pulse();
         step(($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
              2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 9) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised hazard and forwarding unit for the in-order 5-stage scalar+vector core; sits beside the decode stage and drives the pipeline stall and the forwarding-mux selects. It keeps one countdown scoreboard per register file (scalar, vector, ...) that tracks pending writebacks. It detects RAW, load-use and WAW hazards, handles branch flushes, and keeps a saturating stall-cycle counter.

Parameters:
NUM_RF, 2, number of register files tracked (index 0 = scalar, 1 = vector)
NUM_REGS, 32, registers per file; AW = $clog2(NUM_REGS)
NUM_SRC, 2, source operands per instruction
WB_LAT, 3, cycles from issue until the write commits (EX, MEM, WB); CW = $clog2(WB_LAT+1)
ZERO_REG, 1, when 1, register 0 of file 0 is hardwired: never tracked and never hazards

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
id_valid  in  1  decode holds a valid instruction
id_rf  in  $clog2(NUM_RF)  register file used by this instruction (sources and destination)
id_src_addr  in  NUM_SRC*AW  source register addresses, packed, src0 in LSBs
id_src_used  in  NUM_SRC  per-source read enable
id_dst_addr  in  AW  destination register
id_dst_we  in  1  instruction writes id_dst_addr
id_is_load  in  1  result comes from data memory
ex_flush  in  1  branch taken: kill the instruction in decode and the one issued last cycle
stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
issue  out  1  id_valid & ~stall & ~ex_flush
fwd_sel  out  NUM_SRC*CW  per-source bypass select: 0 = register file, k = stage whose count is k
stall_cycles  out  32  saturating count of stalled decode cycles

Behaviour:
- Reset (rst=0, async): all counters, load bits and last-issue register clear; stall=0, issue=0, fwd_sel=0, stall_cycles=0.
- State per file f and register r: cnt[f][r] (CW bits) and ld[f][r].
  - On issue with id_dst_we (and not the zero register): cnt <= WB_LAT, ld <= id_is_load.
  - Otherwise every nonzero cnt decrements by 1 each cycle.
  - Issue to a register whose cnt==1 loads WB_LAT; the issue wins over the decrement.
- Stage mapping for WB_LAT=3: cnt 3 = EX, 2 = MEM, 1 = WB (writes at this edge), 0 = committed.
- Per used source s, with p = cnt[id_rf][addr_s]:
  - With forwarding: hazard if p!=0 & ld & p>1 (load-use; load data exists only in WB).
  - Otherwise fwd_sel_s = p.
  - Unused sources, the zero register and other files: fwd_sel_s = 0 and no hazard.
- WAW: hazard if id_dst_we & cnt[id_rf][id_dst_addr] > 1. This guarantees at most one pending write per register.
- stall = id_valid & ~ex_flush & (any source hazard | WAW). stall is combinational from inputs and state, with no added latency.
- Last-issue register (valid, rf, rd) records each issue with id_dst_we.
  - On ex_flush, if valid, the recorded cnt clears to 0 at the next edge instead of decrementing.
  - The current decode instruction is not issued and not recorded.
- ex_flush and stall in the same cycle: stall=0, issue=0.
- stall_cycles increments when id_valid & stall; it holds at 32'hFFFF_FFFF.
- fwd_sel is meaningful only when issue=1, but it is always driven deterministically.

Optional Feature:
- Macro HAZARD_FWD_EN.
- Defined: forwarding as described above.
- Undefined: fwd_sel tied to 0. Any used source with p!=0 stalls, including p==1, because the register file has no write-through. The WAW rule is unchanged.

Decomposition:
- hazard_pkg: RF_SCALAR=0 / RF_VECTOR=1 constants, FWD_RF=0 constant, the default WB_LAT, and a typedef for the last-issue record.
- Sub-module hazard_rf_track, instantiated NUM_RF times:
  - holds the cnt/ld arrays;
  - implements the set/decrement/flush-clear rules;
  - exposes per-source p and ld lookups.

Test Plan (defaults, HAZARD_FWD_EN defined):
- RAW/ALU: issue scalar ALU op writing x1; next cycle read x1 as src0 -> stall=0, fwd_sel[0]=3. One cycle later, a read of x1 gives fwd_sel=2.
- Load-use: issue a load to x2; next instruction reads x2 -> stall=1 for 2 cycles, then issue=1 with fwd_sel=1; stall_cycles=2.
- WAW plus file independence:
  - Scalar x3 pending (cnt 3): vector op reading v3 -> no stall, fwd_sel=0.
  - Scalar op writing x3 -> stall until x3's cnt==1.
- Zero register: scalar op writing x0, then a read of x0 -> no stall, fwd_sel=0.
- Flush: issue a write to x5; next cycle ex_flush=1 with decode reading x5 -> issue=0. The following cycle a read of x5 -> stall=0, fwd_sel=0.
- Reset mid-operation: pending load to x7 (cnt 2), assert rst=0 for one cycle -> stall=0, stall_cycles=0. After release, a read of x7 gives fwd_sel=0.
